// File: rtl/exu_oitf_if.sv
// Handshake bundle between EXU dispatch/write-back and the OITF.
// Optional macro OITF_PC_EN adds the ret_pc signal.
interface exu_oitf_if #(
   parameter int unsigned ITAG_W  = 1,
   parameter int unsigned RFIDX_W = 5,
   parameter int unsigned PC_W    = 32
) ();

   // Dispatch side
   logic               dis_ena;
   logic               dis_ready;
   logic [ITAG_W-1:0]  dis_ptr;
   logic               dis_rs1en;
   logic               dis_rs2en;
   logic               dis_rdwen;
   logic [RFIDX_W-1:0] dis_rs1idx;
   logic [RFIDX_W-1:0] dis_rs2idx;
   logic [RFIDX_W-1:0] dis_rdidx;
   logic [PC_W-1:0]    dis_pc;

   // Hazard results
   logic               oitfrd_match_disprs1;
   logic               oitfrd_match_disprs2;
   logic               oitfrd_match_disprd;

   // Retire side
   logic               ret_ena;
   logic [ITAG_W-1:0]  ret_ptr;
   logic [RFIDX_W-1:0] ret_rdidx;
   logic               ret_rdwen;
`ifdef OITF_PC_EN
   logic [PC_W-1:0]    ret_pc;
`endif

   logic               oitf_empty;

   // Dispatch / write-back logic
   modport master (
      output dis_ena, dis_rs1en, dis_rs2en, dis_rdwen,
      output dis_rs1idx, dis_rs2idx, dis_rdidx, dis_pc, ret_ena,
      input  dis_ready, dis_ptr,
      input  oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd,
      input  ret_ptr, ret_rdidx, ret_rdwen, oitf_empty
`ifdef OITF_PC_EN
      , input ret_pc
`endif
   );

   // The OITF itself
   modport slave (
      input  dis_ena, dis_rs1en, dis_rs2en, dis_rdwen,
      input  dis_rs1idx, dis_rs2idx, dis_rdidx, dis_pc, ret_ena,
      output dis_ready, dis_ptr,
      output oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd,
      output ret_ptr, ret_rdidx, ret_rdwen, oitf_empty
`ifdef OITF_PC_EN
      , output ret_pc
`endif
   );

endinterface

// File: rtl/exu_oitf.sv
// Outstanding Instruction Track FIFO: tracks long-pipe instructions from
// dispatch to in-order write-back and flags RAW/WAW hazards for dispatch.
// Optional macro OITF_PC_EN: store each entry's PC and drive ret_pc.
module exu_oitf #(
   parameter int unsigned OITF_DEPTH = 2,
   parameter int unsigned RFIDX_W    = 5,
   parameter int unsigned PC_W       = 32
) (
   input logic       clk,
   input logic       rst,
   exu_oitf_if.slave oitf
);

   localparam int unsigned      ItagW   = (OITF_DEPTH > 1) ? $clog2(OITF_DEPTH) : 1;
   localparam logic [ItagW-1:0] LastIdx = ItagW'(OITF_DEPTH - 1);

   // Pointers with wrap flags
   logic [ItagW-1:0] alc_ptr_q, alc_ptr_d;
   logic             alc_flg_q, alc_flg_d;
   logic [ItagW-1:0] ret_ptr_q, ret_ptr_d;
   logic             ret_flg_q, ret_flg_d;

   // Entry storage
   logic [OITF_DEPTH-1:0] vld_q, vld_d;
   logic [OITF_DEPTH-1:0] rdwen_q, rdwen_d;
   logic [RFIDX_W-1:0]    rdidx_q [OITF_DEPTH];
   logic [RFIDX_W-1:0]    rdidx_d [OITF_DEPTH];
`ifdef OITF_PC_EN
   logic [PC_W-1:0]       pc_q [OITF_DEPTH];
   logic [PC_W-1:0]       pc_d [OITF_DEPTH];
`else
   logic                  unused_dis_pc;
   assign unused_dis_pc = ^oitf.dis_pc;
`endif

   logic empty;
   logic full;
   logic alc_fire;
   logic ret_fire;

   assign empty    = (alc_ptr_q == ret_ptr_q) & (alc_flg_q == ret_flg_q);
   assign full     = (alc_ptr_q == ret_ptr_q) & (alc_flg_q != ret_flg_q);
   // Illegal requests are dropped; allocate and retire never hit the same slot.
   assign alc_fire = oitf.dis_ena & ~full;
   assign ret_fire = oitf.ret_ena & ~empty;

   // Next-state: allocate into alc_ptr, retire from ret_ptr, advance pointers
   always_comb begin
      alc_ptr_d = alc_ptr_q;
      alc_flg_d = alc_flg_q;
      ret_ptr_d = ret_ptr_q;
      ret_flg_d = ret_flg_q;
      vld_d     = vld_q;
      rdwen_d   = rdwen_q;
      rdidx_d   = rdidx_q;
`ifdef OITF_PC_EN
      pc_d      = pc_q;
`endif
      if (alc_fire) begin
         vld_d[alc_ptr_q]   = 1'b1;
         rdwen_d[alc_ptr_q] = oitf.dis_rdwen;
         rdidx_d[alc_ptr_q] = oitf.dis_rdidx;
`ifdef OITF_PC_EN
         pc_d[alc_ptr_q]    = oitf.dis_pc;
`endif
         if (alc_ptr_q == LastIdx) begin
            alc_ptr_d = '0;
            alc_flg_d = ~alc_flg_q;
         end else begin
            alc_ptr_d = alc_ptr_q + ItagW'(1);
         end
      end
      if (ret_fire) begin
         vld_d[ret_ptr_q] = 1'b0;
         if (ret_ptr_q == LastIdx) begin
            ret_ptr_d = '0;
            ret_flg_d = ~ret_flg_q;
         end else begin
            ret_ptr_d = ret_ptr_q + ItagW'(1);
         end
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alc_ptr_q <= '0;
         alc_flg_q <= 1'b0;
         ret_ptr_q <= '0;
         ret_flg_q <= 1'b0;
         vld_q     <= '0;
         rdwen_q   <= '0;
         for (int i = 0; i < OITF_DEPTH; i++) begin
            rdidx_q[i] <= '0;
`ifdef OITF_PC_EN
            pc_q[i]    <= '0;
`endif
         end
      end else begin
         alc_ptr_q <= alc_ptr_d;
         alc_flg_q <= alc_flg_d;
         ret_ptr_q <= ret_ptr_d;
         ret_flg_q <= ret_flg_d;
         vld_q     <= vld_d;
         rdwen_q   <= rdwen_d;
         for (int i = 0; i < OITF_DEPTH; i++) begin
            rdidx_q[i] <= rdidx_d[i];
`ifdef OITF_PC_EN
            pc_q[i]    <= pc_d[i];
`endif
         end
      end
   end

   // Hazard compare against registered entries only (no same-cycle bypass)
   logic hit_rs1;
   logic hit_rs2;
   logic hit_rd;
   always_comb begin
      hit_rs1 = 1'b0;
      hit_rs2 = 1'b0;
      hit_rd  = 1'b0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
         hit_rs1 = hit_rs1 | (vld_q[i] & rdwen_q[i] & (rdidx_q[i] == oitf.dis_rs1idx));
         hit_rs2 = hit_rs2 | (vld_q[i] & rdwen_q[i] & (rdidx_q[i] == oitf.dis_rs2idx));
         hit_rd  = hit_rd  | (vld_q[i] & rdwen_q[i] & (rdidx_q[i] == oitf.dis_rdidx));
      end
   end

   // x0 is never a hazard
   assign oitf.oitfrd_match_disprs1 = oitf.dis_rs1en & (oitf.dis_rs1idx != '0) & hit_rs1;
   assign oitf.oitfrd_match_disprs2 = oitf.dis_rs2en & (oitf.dis_rs2idx != '0) & hit_rs2;
   assign oitf.oitfrd_match_disprd  = oitf.dis_rdwen & (oitf.dis_rdidx  != '0) & hit_rd;

   assign oitf.dis_ready  = ~full;
   assign oitf.dis_ptr    = alc_ptr_q;
   assign oitf.ret_ptr    = ret_ptr_q;
   assign oitf.oitf_empty = empty;
   assign oitf.ret_rdidx  = rdidx_q[ret_ptr_q];
   assign oitf.ret_rdwen  = rdwen_q[ret_ptr_q];
`ifdef OITF_PC_EN
   assign oitf.ret_pc     = pc_q[ret_ptr_q];
`endif

`ifndef SYNTHESIS
   // Dispatch must not allocate into a full FIFO
   dis_when_full_a : assert property (@(posedge clk) disable iff (rst)
      !(oitf.dis_ena && full))
      else $error("exu_oitf: dis_ena while full");

   // Write-back must not retire from an empty FIFO
   ret_when_empty_a : assert property (@(posedge clk) disable iff (rst)
      !(oitf.ret_ena && empty))
      else $error("exu_oitf: ret_ena while empty");
`endif

endmodule

// File: tb/tb_exu_oitf.sv
// Self-checking bench for exu_oitf (depth 2); expected retire data is kept
// in a scoreboard queue filled at allocation and drained at retirement.
module tb_exu_oitf;

   typedef struct {
      logic [4:0]  rdidx;
      logic        rdwen;
      logic [31:0] pc;
   } sb_entry_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   sb_entry_t sb [$];

   always #5 clk = ~clk;

   exu_oitf_if #(.ITAG_W(1), .RFIDX_W(5), .PC_W(32)) oitf_bus ();

   exu_oitf #(.OITF_DEPTH(2), .RFIDX_W(5), .PC_W(32)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .oitf (oitf_bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic clear_inputs();
      oitf_bus.dis_ena    = 1'b0;
      oitf_bus.dis_rs1en  = 1'b0;
      oitf_bus.dis_rs2en  = 1'b0;
      oitf_bus.dis_rdwen  = 1'b0;
      oitf_bus.dis_rs1idx = '0;
      oitf_bus.dis_rs2idx = '0;
      oitf_bus.dis_rdidx  = '0;
      oitf_bus.dis_pc     = '0;
      oitf_bus.ret_ena    = 1'b0;
   endtask

   task automatic check_head(input sb_entry_t e);
      check_eq("ret_rdidx", 32'(oitf_bus.ret_rdidx), 32'(e.rdidx));
      check_eq("ret_rdwen", 32'(oitf_bus.ret_rdwen), 32'(e.rdwen));
`ifdef OITF_PC_EN
      check_eq("ret_pc", oitf_bus.ret_pc, e.pc);
`endif
   endtask

   task automatic alloc(input logic [4:0] rd, input logic wen, input logic [31:0] pc);
      sb_entry_t e;
      @(negedge clk);
      clear_inputs();
      e.rdidx = rd; e.rdwen = wen; e.pc = pc;
      sb.push_back(e);
      oitf_bus.dis_ena   = 1'b1;
      oitf_bus.dis_rdidx = rd;
      oitf_bus.dis_rdwen = wen;
      oitf_bus.dis_pc    = pc;
      @(posedge clk);
      #1 clear_inputs();
   endtask

   task automatic retire();
      sb_entry_t e;
      @(negedge clk);
      clear_inputs();
      e = sb.pop_front();
      check_head(e);
      oitf_bus.ret_ena = 1'b1;
      @(posedge clk);
      #1 clear_inputs();
   endtask

   task automatic alloc_retire(input logic [4:0] rd, input logic [31:0] pc);
      sb_entry_t e;
      sb_entry_t n;
      @(negedge clk);
      clear_inputs();
      e = sb.pop_front();
      check_head(e);
      n.rdidx = rd; n.rdwen = 1'b1; n.pc = pc;
      sb.push_back(n);
      oitf_bus.ret_ena   = 1'b1;
      oitf_bus.dis_ena   = 1'b1;
      oitf_bus.dis_rdidx = rd;
      oitf_bus.dis_rdwen = 1'b1;
      oitf_bus.dis_pc    = pc;
      @(posedge clk);
      #1 clear_inputs();
   endtask

   initial begin
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      // Reset state, probing matches with live requests
      oitf_bus.dis_rs1en = 1'b1; oitf_bus.dis_rs1idx = 5'd5;
      oitf_bus.dis_rdwen = 1'b1; oitf_bus.dis_rdidx  = 5'd5;
      #1;
      check_eq("rst_empty", 32'(oitf_bus.oitf_empty), 32'd1);
      check_eq("rst_ready", 32'(oitf_bus.dis_ready), 32'd1);
      check_eq("rst_dis_ptr", 32'(oitf_bus.dis_ptr), 32'd0);
      check_eq("rst_ret_ptr", 32'(oitf_bus.ret_ptr), 32'd0);
      check_eq("rst_ret_rdwen", 32'(oitf_bus.ret_rdwen), 32'd0);
      check_eq("rst_match_rs1", 32'(oitf_bus.oitfrd_match_disprs1), 32'd0);
      check_eq("rst_match_rd", 32'(oitf_bus.oitfrd_match_disprd), 32'd0);
`ifdef OITF_PC_EN
      check_eq("rst_ret_pc", oitf_bus.ret_pc, 32'd0);
`endif

      // Fill to full
      alloc(5'd5, 1'b1, 32'h8000_0000);
      check_eq("fill1_dis_ptr", 32'(oitf_bus.dis_ptr), 32'd1);
      check_eq("fill1_empty", 32'(oitf_bus.oitf_empty), 32'd0);
      check_eq("fill1_ready", 32'(oitf_bus.dis_ready), 32'd1);
      alloc(5'd6, 1'b1, 32'h8000_0004);
      check_eq("fill2_dis_ptr", 32'(oitf_bus.dis_ptr), 32'd0);
      check_eq("full_ready", 32'(oitf_bus.dis_ready), 32'd0);
      check_eq("full_empty", 32'(oitf_bus.oitf_empty), 32'd0);

      // Hazard matches against x5/x6
      oitf_bus.dis_rs1en = 1'b1; oitf_bus.dis_rs1idx = 5'd5;
      oitf_bus.dis_rdwen = 1'b1; oitf_bus.dis_rdidx  = 5'd6;
      oitf_bus.dis_rs2en = 1'b1; oitf_bus.dis_rs2idx = 5'd7;
      #1;
      check_eq("haz_rs1_x5", 32'(oitf_bus.oitfrd_match_disprs1), 32'd1);
      check_eq("haz_rd_x6", 32'(oitf_bus.oitfrd_match_disprd), 32'd1);
      check_eq("haz_rs2_x7", 32'(oitf_bus.oitfrd_match_disprs2), 32'd0);
      clear_inputs();

      // In-order retire
      retire();
      check_eq("ret1_ret_ptr", 32'(oitf_bus.ret_ptr), 32'd1);
      check_eq("ret1_ready", 32'(oitf_bus.dis_ready), 32'd1);
      retire();
      check_eq("ret2_empty", 32'(oitf_bus.oitf_empty), 32'd1);
      check_eq("ret2_ret_ptr", 32'(oitf_bus.ret_ptr), 32'd0);

      // Simultaneous allocate and retire at occupancy 1
      alloc(5'd5, 1'b1, 32'h8000_0008);
      alloc_retire(5'd9, 32'h8000_000c);
      check_eq("sim_empty", 32'(oitf_bus.oitf_empty), 32'd0);
      check_eq("sim_ready", 32'(oitf_bus.dis_ready), 32'd1);
      check_eq("sim_ret_ptr", 32'(oitf_bus.ret_ptr), 32'd1);
      check_eq("sim_dis_ptr", 32'(oitf_bus.dis_ptr), 32'd0);
      retire();
      check_eq("sim_drain_empty", 32'(oitf_bus.oitf_empty), 32'd1);
      check_eq("sim_drain_ret_ptr", 32'(oitf_bus.ret_ptr), 32'd0);

      // Masking: rdwen=0 entry, x0 destination, rs1en=0
      alloc(5'd3, 1'b0, 32'h8000_0010);
      alloc(5'd0, 1'b1, 32'h8000_0014);
      oitf_bus.dis_rs1en = 1'b1; oitf_bus.dis_rs1idx = 5'd3;
      #1;
      check_eq("mask_nowen", 32'(oitf_bus.oitfrd_match_disprs1), 32'd0);
      oitf_bus.dis_rs1idx = 5'd0;
      oitf_bus.dis_rdwen  = 1'b1; oitf_bus.dis_rdidx = 5'd0;
      #1;
      check_eq("mask_x0_rs1", 32'(oitf_bus.oitfrd_match_disprs1), 32'd0);
      check_eq("mask_x0_rd", 32'(oitf_bus.oitfrd_match_disprd), 32'd0);
      clear_inputs();
      retire();
      alloc(5'd12, 1'b1, 32'h8000_0018);
      oitf_bus.dis_rs1en = 1'b1; oitf_bus.dis_rs1idx = 5'd12;
      oitf_bus.dis_rs2en = 1'b1; oitf_bus.dis_rs2idx = 5'd12;
      #1;
      check_eq("haz_rs1_x12", 32'(oitf_bus.oitfrd_match_disprs1), 32'd1);
      check_eq("haz_rs2_x12", 32'(oitf_bus.oitfrd_match_disprs2), 32'd1);
      oitf_bus.dis_rs1en = 1'b0;
      #1;
      check_eq("mask_rs1en0", 32'(oitf_bus.oitfrd_match_disprs1), 32'd0);

      // Asynchronous reset mid-cycle with two entries outstanding
      oitf_bus.dis_rs1en = 1'b1;
      #1 rst = 1'b1;
      #1;
      check_eq("arst_empty", 32'(oitf_bus.oitf_empty), 32'd1);
      check_eq("arst_ready", 32'(oitf_bus.dis_ready), 32'd1);
      check_eq("arst_match_rs1", 32'(oitf_bus.oitfrd_match_disprs1), 32'd0);
      check_eq("arst_match_rs2", 32'(oitf_bus.oitfrd_match_disprs2), 32'd0);
      check_eq("arst_dis_ptr", 32'(oitf_bus.dis_ptr), 32'd0);
`ifdef OITF_PC_EN
      check_eq("arst_ret_pc", oitf_bus.ret_pc, 32'd0);
`endif
      sb.delete();
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;

      // Operation after reset
      alloc(5'd17, 1'b1, 32'h8000_0010);
`ifdef OITF_PC_EN
      check_eq("post_ret_pc", oitf_bus.ret_pc, 32'h8000_0010);
`endif
      oitf_bus.dis_rs1en = 1'b1; oitf_bus.dis_rs1idx = 5'd17;
      #1;
      check_eq("post_haz_rs1", 32'(oitf_bus.oitfrd_match_disprs1), 32'd1);
      clear_inputs();
      retire();
      check_eq("post_empty", 32'(oitf_bus.oitf_empty), 32'd1);
      check_eq("post_ret_ptr", 32'(oitf_bus.ret_ptr), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
